// File: rtl/rgb_fade_ctrl.sv
// RGB LED PWM sequencer: takes colour commands and walks each channel level 1 LSB per step.
// Define RGB_FADE_GAMMA_EN for a square-law gamma duty mapping; the default build is linear.
module rgb_fade_ctrl #(
  parameter int PWM_BITS  = 8,
  parameter int RATE_BITS = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [PWM_BITS-1:0]  cmd_r,
  input  logic [PWM_BITS-1:0]  cmd_g,
  input  logic [PWM_BITS-1:0]  cmd_b,
  input  logic [RATE_BITS-1:0] cmd_rate,
  output logic                 pwm_r,
  output logic                 pwm_g,
  output logic                 pwm_b,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  localparam logic [PWM_BITS-1:0]  LVL_ONE   = PWM_BITS'(1'b1);
  localparam logic [PWM_BITS-1:0]  CNT_MAX   = {PWM_BITS{1'b1}};
  localparam logic [RATE_BITS-1:0] RATE_ONE  = RATE_BITS'(1'b1);
  localparam logic [RATE_BITS-1:0] RATE_ZERO = {RATE_BITS{1'b0}};

  state_t                   state_q;
  logic [PWM_BITS-1:0]      pwm_cnt_q;
  logic [2:0][PWM_BITS-1:0] level_q;
  logic [2:0][PWM_BITS-1:0] level_d;
  logic [2:0][PWM_BITS-1:0] duty_q;
  logic [2:0][PWM_BITS-1:0] target_q;
  logic [2:0][PWM_BITS-1:0] cmd_lvl_s;
  logic [RATE_BITS-1:0]     rate_q;
  logic [RATE_BITS-1:0]     rate_cnt_q;
  logic [2:0]               pwm_q;
  logic                     done_q;
  logic                     boundary_s;
  logic                     xfer_s;
  logic                     jump_s;
  logic                     step_due_s;

  function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] lvl);
`ifdef RGB_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = lvl * lvl;
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return lvl;
`endif
  endfunction

  assign cmd_lvl_s  = {cmd_b, cmd_g, cmd_r};
  assign boundary_s = (pwm_cnt_q == CNT_MAX);
  assign xfer_s     = cmd_valid && (state_q == ST_IDLE);
  assign jump_s     = (cmd_rate == RATE_ZERO) || (cmd_lvl_s == level_q);
  assign step_due_s = (rate_cnt_q <= RATE_ONE);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_FADE);
  assign done      = done_q;
  assign pwm_r     = pwm_q[0];
  assign pwm_g     = pwm_q[1];
  assign pwm_b     = pwm_q[2];

  // Each channel moves one LSB toward its target; a channel on target holds.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      if (level_q[i] < target_q[i]) begin
        level_d[i] = level_q[i] + LVL_ONE;
      end else if (level_q[i] > target_q[i]) begin
        level_d[i] = level_q[i] - LVL_ONE;
      end else begin
        level_d[i] = level_q[i];
      end
    end
  end

  // PWM counter, duty reload at the period boundary, and the command/fade FSM.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pwm_cnt_q  <= '0;
      level_q    <= '0;
      duty_q     <= '0;
      target_q   <= '0;
      rate_q     <= RATE_ZERO;
      rate_cnt_q <= RATE_ZERO;
      pwm_q      <= 3'b000;
      done_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + LVL_ONE;
      for (int i = 0; i < 3; i++) begin
        pwm_q[i] <= (pwm_cnt_q < duty_q[i]);
        if (boundary_s) begin
          duty_q[i] <= duty_map(level_q[i]);
        end
      end
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (xfer_s) begin
            target_q <= cmd_lvl_s;
            if (jump_s) begin
              level_q <= cmd_lvl_s;
              done_q  <= 1'b1;
            end else begin
              rate_q     <= cmd_rate;
              rate_cnt_q <= cmd_rate;
              state_q    <= ST_FADE;
            end
          end
        end
        ST_FADE: begin
          // Steps only land on boundaries, so the duty just loaded still uses the old level.
          if (boundary_s) begin
            if (step_due_s) begin
              level_q    <= level_d;
              rate_cnt_q <= rate_q;
              if (level_d == target_q) begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end else begin
              rate_cnt_q <= rate_cnt_q - RATE_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Scoreboard bench for rgb_fade_ctrl: a timing-level reference model queues expected
// per-period duties, done pulses and handshake state; a monitor measures the DUT and compares.
module tb_rgb_fade_ctrl;

  localparam int PW  = 4;
  localparam int RW  = 8;
  localparam int PER = 1 << PW;

  logic          sys_clk   = 1'b0;
  logic          rst       = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [PW-1:0] cmd_r     = '0;
  logic [PW-1:0] cmd_g     = '0;
  logic [PW-1:0] cmd_b     = '0;
  logic [RW-1:0] cmd_rate  = '0;
  logic          cmd_ready;
  logic          pwm_r;
  logic          pwm_g;
  logic          pwm_b;
  logic          busy;
  logic          done;

  rgb_fade_ctrl #(.PWM_BITS(PW), .RATE_BITS(RW)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_r     (cmd_r),
    .cmd_g     (cmd_g),
    .cmd_b     (cmd_b),
    .cmd_rate  (cmd_rate),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b),
    .busy      (busy),
    .done      (done)
  );

  // Clock generation.
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    int r;
    int g;
    int b;
  } trip_t;

  trip_t      exp_duty_q[$];
  int         exp_done_q[$];
  logic [1:0] exp_ctl_q[$];

  // Cycle counter used to timestamp expected done pulses.
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int to_duty(input int lvl);
`ifdef RGB_FADE_GAMMA_EN
    return (lvl * lvl) / PER;
`else
    return lvl;
`endif
  endfunction

  int  m_ph;
  int  m_rate;
  int  m_nb;
  int  m_lvl[3];
  int  m_start[3];
  int  m_tgt[3];
  bit  m_fade;

  // Reference model: level = start +/- min(distance, boundaries_elapsed / rate).
  always @(negedge sys_clk) begin : ref_model
    int  c[3];
    int  d;
    int  steps;
    bit  all_at;
    bit  same;
    if (rst) begin
      m_ph   = 0;
      m_fade = 1'b0;
      for (int i = 0; i < 3; i++) m_lvl[i] = 0;
      exp_duty_q.delete();
      exp_done_q.delete();
      exp_ctl_q.delete();
      exp_ctl_q.push_back(2'b01);
    end else begin
      c[0] = int'(cmd_r);
      c[1] = int'(cmd_g);
      c[2] = int'(cmd_b);
      if (m_ph == PER - 1) begin
        exp_duty_q.push_back('{to_duty(m_lvl[0]), to_duty(m_lvl[1]), to_duty(m_lvl[2])});
      end
      if (m_fade && (m_ph == PER - 1)) begin
        m_nb++;
        all_at = 1'b1;
        for (int i = 0; i < 3; i++) begin
          d     = (m_tgt[i] >= m_start[i]) ? (m_tgt[i] - m_start[i]) : (m_start[i] - m_tgt[i]);
          steps = m_nb / m_rate;
          if (steps > d) steps = d;
          m_lvl[i] = (m_tgt[i] >= m_start[i]) ? (m_start[i] + steps) : (m_start[i] - steps);
          if (steps < d) all_at = 1'b0;
        end
        if (all_at) begin
          m_fade = 1'b0;
          exp_done_q.push_back(cyc + 1);
        end
      end else if (!m_fade && cmd_valid) begin
        same = 1'b1;
        for (int i = 0; i < 3; i++) if (c[i] != m_lvl[i]) same = 1'b0;
        if ((cmd_rate == '0) || same) begin
          for (int i = 0; i < 3; i++) m_lvl[i] = c[i];
          exp_done_q.push_back(cyc + 1);
        end else begin
          m_fade = 1'b1;
          m_rate = int'(cmd_rate);
          m_nb   = 0;
          for (int i = 0; i < 3; i++) begin
            m_start[i] = m_lvl[i];
            m_tgt[i]   = c[i];
          end
        end
      end
      m_ph = (m_ph + 1) % PER;
      exp_ctl_q.push_back({m_fade, !m_fade});
    end
  end

  // Monitor: measures high time per PWM period and checks done/busy/ready against the queues.
  always @(negedge sys_clk) begin : monitor
    int         mph;
    bit         armed;
    bit         seen;
    int         acc[3];
    trip_t      et;
    logic [1:0] ec;
    if (rst) begin
      chk("reset_outputs", int'({pwm_r, pwm_g, pwm_b, busy, done}), 0);
      mph   = 0;
      armed = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 3; i++) acc[i] = 0;
    end else begin
      if (exp_ctl_q.size() == 0) begin
        chk("ctl_queue_empty", 1, 0);
      end else begin
        ec = exp_ctl_q.pop_front();
        chk("busy_ready", int'({busy, cmd_ready}), int'(ec));
      end
      if ((exp_done_q.size() != 0) && (exp_done_q[0] == cyc)) begin
        void'(exp_done_q.pop_front());
        chk("done_pulse", int'(done), 1);
      end else begin
        chk("done_quiet", int'(done), 0);
      end
      acc[0] += int'(pwm_r);
      acc[1] += int'(pwm_g);
      acc[2] += int'(pwm_b);
      if (mph == 0) begin
        if (armed) begin
          if (exp_duty_q.size() == 0) begin
            chk("duty_queue_empty", 1, 0);
          end else begin
            et = exp_duty_q.pop_front();
            chk("duty_r", acc[0], et.r);
            chk("duty_g", acc[1], et.g);
            chk("duty_b", acc[2], et.b);
          end
        end
        armed = seen;
        for (int i = 0; i < 3; i++) acc[i] = 0;
      end
      if (mph == PER - 1) seen = 1'b1;
      mph = (mph + 1) % PER;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic scramble_cmd();
    cmd_r    = PW'($urandom_range(0, PER - 1));
    cmd_g    = PW'($urandom_range(0, PER - 1));
    cmd_b    = PW'($urandom_range(0, PER - 1));
    cmd_rate = RW'($urandom_range(0, 3));
  endtask

  task automatic send(input int r, input int g, input int b, input int rate, input bit scramble);
    int waited;
    bit taken;
    cmd_r     = PW'(r);
    cmd_g     = PW'(g);
    cmd_b     = PW'(b);
    cmd_rate  = RW'(rate);
    cmd_valid = 1'b1;
    waited    = 0;
    taken     = 1'b0;
    while (!taken && (waited < 3000)) begin
      @(negedge sys_clk);
      taken = cmd_ready;
      @(posedge sys_clk);
      #1;
      waited++;
      if (!taken && scramble) scramble_cmd();
    end
    cmd_valid = 1'b0;
    scramble_cmd();
    if (!taken) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout at cycle %0d: cmd_ready got 0, expected 1", cyc);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy && (n < limit)) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout at cycle %0d: busy got 1, expected 0", cyc);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  // Directed scenarios followed by randomized commands.
  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);

    send(8, 0, 15, 0, 1'b0);
    tick(3 * PER);

    pulse_reset(3);
    tick(2);
    send(3, 0, 0, 2, 1'b0);
    send(0, 0, 0, 1, 1'b0);
    wait_idle(2000);
    tick(2 * PER);

    send(0, 0, 0, 5, 1'b0);
    tick(PER);

    send(15, 0, 0, 1, 1'b0);
    tick(5 * PER + 3);
    pulse_reset(3);
    tick(2);
    send(4, 9, 0, 0, 1'b0);
    tick(3 * PER);

    for (int k = 0; k < 40; k++) begin
      tick($urandom_range(1, 20));
      send($urandom_range(0, PER - 1), $urandom_range(0, PER - 1),
           $urandom_range(0, PER - 1), $urandom_range(0, 3), 1'b1);
      if ((k % 13) == 7) begin
        tick($urandom_range(20, 200));
        pulse_reset(2);
      end
    end
    wait_idle(3000);
    tick(3 * PER);
    chk("done_pending", exp_done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
